sbox_share_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency, non-stallable forward S-box pipeline (8-stage bit-serial affine datapath) among NUM_REQ byte requesters (e.g. four state-column lanes or the key-expansion SubWord path). It accepts at most one byte per cycle, issues it to the S-box, and carries a requester tag alongside the data through a matching delay line. When the S-box result emerges, it routes the result back to the originating requester. It also provides drain/idle control so the round sequencer can quiesce the S-box between rounds.

---
 rtl/sbox_share_arbiter.sv | 124 ++++++++++++
 tb/tb_sbox_share_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
// Round-robin arbiter that shares one fixed-latency, non-stallable S-box
// pipeline among NUM_REQ byte requesters. One byte is accepted per cycle,
// registered into the S-box, and its requester id travels down a matching
// tag line so the result can be routed back when it emerges.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid       per-requester byte available
//   req_data        byte for requester i at [8i+7:8i]
//   req_ready       one-hot combinational grant
//   req_enable      per-requester grant mask
//   drain           blocks new grants; in-flight bytes still complete
//   sbox_idata      registered byte into the S-box
//   sbox_ivalid     registered qualifier for sbox_idata
//   sbox_odata      S-box result, SBOX_LATENCY cycles after input
//   rsp_valid       one-hot, single-cycle result strobe per requester
//   rsp_data        result byte (sbox_odata), qualified by rsp_valid
//   inflight        accepted bytes whose response has not yet pulsed
//   idle            nothing in flight and no transfer this cycle
module sbox_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SBOX_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_enable,
    input  logic                 drain,
    output logic [7:0]           sbox_idata,
    output logic                 sbox_ivalid,
    input  logic [7:0]           sbox_odata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [3:0]           inflight,
    output logic                 idle
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    issue_tag;
    logic [SBOX_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [SBOX_LATENCY];
    logic               rsp_fire;
    int                 idx;

    // The grant never looks at response state: the S-box cannot stall, so
    // every accepted byte is guaranteed a slot on the way back.
    assign eligible = drain ? '0 : (req_valid & req_enable);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && eligible[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_fire = tag_v[SBOX_LATENCY-1];
    assign rsp_data = sbox_odata;
    assign idle     = (inflight == 4'd0) && !grant_any;

    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) begin
            rsp_valid[tag_id[SBOX_LATENCY-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            sbox_idata  <= 8'h00;
            sbox_ivalid <= 1'b0;
            issue_tag   <= '0;
            tag_v       <= '0;
            inflight    <= 4'd0;
            for (int i = 0; i < SBOX_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            sbox_ivalid <= grant_any;
            if (grant_any) begin
                ptr        <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                sbox_idata <= req_data[int'(grant_idx)*8 +: 8];
                issue_tag  <= grant_idx;
            end

            // Tag line is fed from the issue register so it stays aligned
            // with the byte the S-box is actually consuming.
            tag_v[0]  <= sbox_ivalid;
            tag_id[0] <= issue_tag;
            for (int i = 1; i < SBOX_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            case ({grant_any, rsp_fire})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
module tb_sbox_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic [3:0]  req_enable = 4'b1111;
    logic        drain = 1'b0;
    logic [7:0]  sbox_idata;
    logic        sbox_ivalid;
    logic [7:0]  sbox_odata;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  inflight;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses_seen = 0;

    sbox_share_arbiter #(.NUM_REQ(4), .SBOX_LATENCY(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .req_enable(req_enable), .drain(drain),
        .sbox_idata(sbox_idata), .sbox_ivalid(sbox_ivalid), .sbox_odata(sbox_odata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Stand-in S-box: any bijection works since the arbiter only routes data.
    function automatic logic [7:0] sx(input logic [7:0] x);
        return x ^ 8'h9C;
    endfunction

    logic [7:0] hist [8];
    always @(posedge clk) begin
        hist[0] <= sbox_idata;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end
    assign sbox_odata = sx(hist[7]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every transfer must come back once, in order, 9 cycles later.
    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    exp_t new_e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            if (rsp_valid != 4'b0) begin
                pulses_seen++;
                if (q.size() == 0) begin
                    chk("rsp_unexpected", {28'h0, rsp_valid}, 32'h0);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_id", {28'h0, rsp_valid}, 32'h1 << mon_e.id);
                    chk("rsp_data", {24'h0, rsp_data}, {24'h0, sx(mon_e.data)});
                    chk("rsp_latency", cyc, mon_e.due);
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                mon_e = q.pop_front();
                chk("rsp_missing", {28'h0, rsp_valid}, 32'h1 << mon_e.id);
            end
            if ((req_valid & req_ready) != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        new_e.id   = i;
                        new_e.data = req_data[8*i +: 8];
                        new_e.due  = cyc + 9;
                        q.push_back(new_e);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] enable;
        logic       drn;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs[20];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'b0;
        drain     = 1'b0;
        rst       = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int p2;
        int peak;
        int base;
        bit prev_pulse;
        bit idle_done;

        // fairness, mask, drain and pointer rows, starting from ptr = 0
        for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 4'b1111, 1'b0, 4'b0001 << (i % 4)};
        vecs[8]  = '{4'b1111, 4'b1010, 1'b0, 4'b0010};
        vecs[9]  = '{4'b1111, 4'b1010, 1'b0, 4'b1000};
        vecs[10] = '{4'b1111, 4'b1010, 1'b0, 4'b0010};
        vecs[11] = '{4'b1111, 4'b1010, 1'b0, 4'b1000};
        vecs[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0000};
        vecs[13] = '{4'b0000, 4'b1111, 1'b0, 4'b0000};
        vecs[14] = '{4'b0100, 4'b1111, 1'b0, 4'b0100};
        vecs[15] = '{4'b0111, 4'b1111, 1'b0, 4'b0001};
        vecs[16] = '{4'b0101, 4'b1111, 1'b0, 4'b0100};
        vecs[17] = '{4'b0011, 4'b0001, 1'b0, 4'b0001};
        vecs[18] = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
        vecs[19] = '{4'b1001, 4'b1111, 1'b0, 4'b1000};

        // reset values
        @(negedge clk);
        chk("rst_ivalid", {31'h0, sbox_ivalid}, 32'h0);
        chk("rst_idata", {24'h0, sbox_idata}, 32'h0);
        chk("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
        chk("rst_inflight", {28'h0, inflight}, 32'h0);
        chk("rst_idle", {31'h0, idle}, 32'h1);
        chk("rst_ready", {28'h0, req_ready}, 32'h0);
        next_cycle();
        rst = 1'b0;

        // single byte
        next_cycle();
        req_valid = 4'b0001;
        req_data  = 32'h000000BB;
        @(negedge clk);
        chk("single_ready", {28'h0, req_ready}, 32'h1);
        chk("single_idle_busy", {31'h0, idle}, 32'h0);
        next_cycle();
        req_valid = 4'b0;
        @(negedge clk);
        chk("single_inflight1", {28'h0, inflight}, 32'h1);
        chk("single_ivalid", {31'h0, sbox_ivalid}, 32'h1);
        chk("single_idata", {24'h0, sbox_idata}, 32'hBB);
        lat = 0;
        for (int i = 2; i <= 14; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0) begin
                lat = i;
                break;
            end
        end
        chk("single_latency", lat, 9);
        chk("single_rsp_valid", {28'h0, rsp_valid}, 32'h1);
        chk("single_rsp_data", {24'h0, rsp_data}, 32'h27);
        @(negedge clk);
        chk("single_inflight0", {28'h0, inflight}, 32'h0);
        chk("single_idle", {31'h0, idle}, 32'h1);

        // table: fairness, mask, drain, pointer search
        do_reset();
        req_data = 32'h13121110;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            req_valid  = vecs[i].valid;
            req_enable = vecs[i].enable;
            drain      = vecs[i].drn;
            @(negedge clk);
            chk($sformatf("grant_row%0d", i), {28'h0, req_ready}, {28'h0, vecs[i].exp_ready});
        end
        next_cycle();
        req_valid  = 4'b0;
        req_enable = 4'b1111;
        drain      = 1'b0;
        repeat (12) next_cycle();
        @(negedge clk);
        chk("table_inflight", {28'h0, inflight}, 32'h0);
        chk("table_idle", {31'h0, idle}, 32'h1);
        chk("table_queue_empty", q.size(), 0);

        // drain after a 5-byte stream from requester 2
        p2 = 0;
        prev_pulse = 1'b0;
        idle_done = 1'b0;
        next_cycle();
        for (int i = 0; i < 25; i++) begin
            req_valid = 4'b0100;
            if (i < 5) begin
                req_data[23:16] = 8'h40 + 8'(i);
                drain = 1'b0;
            end else begin
                drain = 1'b1;
            end
            @(negedge clk);
            chk("drain_ready", {28'h0, req_ready}, (i < 5) ? 32'h4 : 32'h0);
            if (rsp_valid == 4'b0100) p2++;
            if (prev_pulse && rsp_valid == 4'b0 && !idle_done) begin
                chk("drain_idle", {31'h0, idle}, 32'h1);
                chk("drain_inflight", {28'h0, inflight}, 32'h0);
                idle_done = 1'b1;
            end
            prev_pulse = (rsp_valid != 4'b0);
            next_cycle();
        end
        chk("drain_pulses", p2, 5);
        chk("drain_idle_seen", {31'h0, idle_done}, 32'h1);
        drain = 1'b0;
        req_valid = 4'b0;

        // reset with three bytes in flight
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001;
            req_data[7:0] = 8'h55 + 8'(i);
            @(negedge clk);
            chk("midrst_ready", {28'h0, req_ready}, 32'h1);
            next_cycle();
        end
        req_valid = 4'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {28'h0, rsp_valid}, 32'h0);
        end
        chk("midrst_inflight", {28'h0, inflight}, 32'h0);
        chk("midrst_idle", {31'h0, idle}, 32'h1);

        // saturation: 12 back-to-back bytes across rotating requesters
        peak = 0;
        base = pulses_seen;
        next_cycle();
        for (int k = 0; k < 12; k++) begin
            req_valid = 4'b0001 << (k % 4);
            req_data[8*(k%4) +: 8] = 8'hA0 + 8'(k);
            @(negedge clk);
            chk("sat_ready", {28'h0, req_ready}, {28'h0, 4'b0001 << (k % 4)});
            if (int'(inflight) > peak) peak = int'(inflight);
            next_cycle();
        end
        req_valid = 4'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
            next_cycle();
        end
        @(negedge clk);
        chk("sat_peak", peak, 9);
        chk("sat_pulses", pulses_seen - base, 12);
        chk("sat_inflight", {28'h0, inflight}, 32'h0);
        chk("sat_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
